// File: rtl/ysyx_22050710_ifu.sv
// ysyx_22050710_ifu: instruction fetch unit with single-outstanding memory fetch and decode handshake.
// Defining YSYX_22050710_IFU_ALIGN_CHECK_EN adds o_misalign and a sticky error state for misaligned redirects.
module ysyx_22050710_ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst,
`ifdef YSYX_22050710_IFU_ALIGN_CHECK_EN
  output logic        o_misalign,
`endif
  output logic        o_mem_req,
  output logic [63:0] o_mem_addr,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [63:0] o_pc,
  input  logic        i_id_ready,
  input  logic        i_redirect,
  input  logic [63:0] i_redirect_pc
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, IDLE_ERR} state_t;
  state_t state, state_n;
  logic [63:0] pc, pc_n;
  logic [31:0] inst_q, inst_n;
  logic drop, drop_n;
`ifdef YSYX_22050710_IFU_ALIGN_CHECK_EN
  logic mis, mis_n;
  assign o_misalign = mis;
  always_ff @(posedge i_clk) mis <= i_rst ? 1'b0 : mis_n;
`endif
  assign o_mem_req    = state == REQ;
  assign o_mem_addr   = pc;
  assign o_inst_valid = state == HOLD;
  assign o_inst       = state == HOLD ? inst_q : NOP_INST;
  assign o_pc         = pc;
  always_comb begin
    state_n = state;
    pc_n    = pc;
    drop_n  = drop;
    inst_n  = inst_q;
    unique case (state)
      IDLE: state_n = REQ;
      REQ: begin
        state_n = i_mem_gnt ? WAIT : REQ;
        drop_n  = i_redirect & i_mem_gnt;
        pc_n    = i_redirect ? i_redirect_pc : pc;
      end
      WAIT: begin
        pc_n    = i_redirect ? i_redirect_pc : pc;
        drop_n  = i_mem_rvalid ? 1'b0 : drop | i_redirect;
        state_n = !i_mem_rvalid ? WAIT : (drop | i_redirect) ? REQ : HOLD;
        inst_n  = (i_mem_rvalid & ~drop & ~i_redirect) ? i_mem_rdata : inst_q;
      end
      HOLD: begin
        pc_n    = i_redirect ? i_redirect_pc : i_id_ready ? pc + 64'd4 : pc;
        state_n = (i_redirect | i_id_ready) ? REQ : HOLD;
      end
      default: state_n = state;
    endcase
`ifdef YSYX_22050710_IFU_ALIGN_CHECK_EN
    mis_n = mis;
    if (i_redirect && |i_redirect_pc[1:0] && (state == REQ || state == WAIT || state == HOLD)) begin
      state_n = IDLE_ERR;
      mis_n   = 1'b1;
    end
`endif
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      drop   <= 1'b0;
      inst_q <= NOP_INST;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      drop   <= drop_n;
      inst_q <= inst_n;
    end
  end
endmodule

// File: tb/tb_ysyx_22050710_ifu.sv
// tb_ysyx_22050710_ifu: randomized bench against a flag-based fetch model and a latency-randomizing memory.
module tb_ysyx_22050710_ifu;
  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef YSYX_22050710_IFU_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
  logic misalign;
`else
  localparam bit ALIGN = 1'b0;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, mem_req, mem_gnt, mem_rvalid, inst_valid, id_ready, redirect;
  logic [63:0] mem_addr, pc_o, redirect_pc;
  logic [31:0] mem_rdata, inst;
  ysyx_22050710_ifu dut (
    .i_clk(clk), .i_rst(rst),
`ifdef YSYX_22050710_IFU_ALIGN_CHECK_EN
    .o_misalign(misalign),
`endif
    .o_mem_req(mem_req), .o_mem_addr(mem_addr), .i_mem_gnt(mem_gnt),
    .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
    .o_inst_valid(inst_valid), .o_inst(inst), .o_pc(pc_o),
    .i_id_ready(id_ready), .i_redirect(redirect), .i_redirect_pc(redirect_pc)
  );
  int checks = 0, errors = 0;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] word_at(logic [63:0] a);
    return (a[31:0] * 32'h9e37_79b1) ^ a[63:32] ^ 32'h0000_0013;
  endfunction
  function automatic logic [63:0] pick_target();
    logic [63:0] t;
    t = RST_PC + 64'({$urandom_range(0, 1023), 2'b00});
    if ($urandom_range(0, 15) == 0) t = 64'hffff_ffff_ffff_fffc;
    if ($urandom_range(0, 29) == 0) t[1:0] = 2'($urandom_range(1, 3));
    return t;
  endfunction
  // model: started = past the post-reset cycle, out = fetch granted and unanswered,
  // stale = that fetch must be discarded, held = an instruction sits before decode
  logic [63:0] m_pc, pend_addr;
  bit m_started, m_out, m_stale, m_held, m_err, req_e, pend;
  int wait_n;
  initial begin
    rst = 1; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; id_ready = 0; redirect = 0; redirect_pc = 0;
    m_pc = RST_PC; m_started = 0; m_out = 0; m_stale = 0; m_held = 0; m_err = 0; pend = 0; wait_n = 0;
    pend_addr = 0;
    @(posedge clk);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      req_e = m_started && !m_out && !m_held && !m_err;
      check("valid", 64'(inst_valid), 64'(m_held));
      check("pc", pc_o, m_pc);
      check("inst", 64'(inst), 64'(m_held ? word_at(m_pc) : NOP));
      check("req", 64'(mem_req), 64'(req_e));
      if (req_e) check("addr", mem_addr, m_pc);
`ifdef YSYX_22050710_IFU_ALIGN_CHECK_EN
      check("misalign", 64'(misalign), 64'(m_err));
`endif
      rst         = (i < 2) || ($urandom_range(0, 199) == 0);
      mem_gnt     = $urandom_range(0, 2) != 0;
      id_ready    = $urandom_range(0, 4) > 1;
      redirect    = $urandom_range(0, 9) == 0;
      redirect_pc = pick_target();
      mem_rdata   = $urandom;
      mem_rvalid  = 0;
      if (pend && wait_n == 0) begin
        mem_rvalid = 1;
        mem_rdata  = word_at(pend_addr);
      end else if (!pend && !m_out && $urandom_range(0, 7) == 0) mem_rvalid = 1;
      if (rst) pend = 0;
      else begin
        if (pend) begin
          if (wait_n == 0) pend = 0;
          else wait_n--;
        end
        if (mem_req && mem_gnt) begin
          pend = 1;
          wait_n = $urandom_range(0, 2);
          pend_addr = mem_addr;
        end
      end
      if (rst) begin
        m_pc = RST_PC; m_started = 0; m_out = 0; m_stale = 0; m_held = 0; m_err = 0;
      end else if (!m_started) m_started = 1;
      else if (!m_err) begin
        if (!m_out && !m_held) begin
          if (mem_gnt) begin
            m_out = 1;
            m_stale = redirect;
          end
        end else if (m_out) begin
          if (mem_rvalid) begin
            m_held = !m_stale && !redirect;
            m_out = 0;
            m_stale = 0;
          end else if (redirect) m_stale = 1;
        end else begin
          if (!redirect && id_ready) m_pc = m_pc + 64'd4;
          if (redirect || id_ready) m_held = 0;
        end
        if (redirect) m_pc = redirect_pc;
        if (ALIGN && redirect && redirect_pc[1:0] != 2'b00) begin
          m_err = 1; m_held = 0; m_out = 0; m_stale = 0;
        end
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ysyx_22050710_ifu.md
Name: ysyx_22050710_ifu

Overview:
Instruction fetch unit. It is the producer side of the instruction interface into the decode stage: it holds the PC, issues word fetches to instruction memory over a request/grant plus response-valid handshake, and presents {o_inst, o_pc} to decode with a valid/ready handshake. It accepts PC redirects from branch/jump resolution and discards any fetch still in flight when a redirect arrives.

Parameters:
RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset.
NOP_INST, 32'h0000_0013, value driven on o_inst when no instruction is held (addi x0,x0,0).

Ports:
i_clk  input  1  clock; all state updates on rising edge.
i_rst  input  1  reset, synchronous, active-high.
o_mem_req  output  1  fetch request valid.
o_mem_addr  output  64  fetch address; equals the current PC while o_mem_req=1.
i_mem_gnt  input  1  request accepted this cycle (handshake = o_mem_req & i_mem_gnt).
i_mem_rvalid  input  1  response data valid; at most one outstanding request; response arrives ≥1 cycle after grant.
i_mem_rdata  input  32  instruction word.
o_inst_valid  output  1  o_inst/o_pc valid to decode.
o_inst  output  32  fetched instruction.
o_pc  output  64  PC of o_inst.
i_id_ready  input  1  decode accepts (transfer = o_inst_valid & i_id_ready).
i_redirect  input  1  PC redirect pulse.
i_redirect_pc  input  64  redirect target.

Behaviour:
- Registers: pc[63:0], state, drop flag, inst_q[31:0]. All outputs come from registers or the state decode; there is no combinational path from i_mem_rdata to o_inst.
- Reset (i_rst=1 at edge): pc=RESET_PC, state=IDLE, drop=0, inst_q=NOP_INST. Outputs: o_mem_req=0, o_inst_valid=0, o_inst=NOP_INST, o_pc=RESET_PC. Reset overrides every other input, including an in-flight fetch. Instruction memory shares i_rst, so no stale response follows reset.
- FSM states:
  - IDLE: lasts one cycle after reset, then goes to REQ.
  - REQ: o_mem_req=1, o_mem_addr=pc.
    - i_mem_gnt=1 → WAIT.
    - i_redirect=1 without gnt → pc=i_redirect_pc, stay in REQ. The address may change while ungranted.
    - i_redirect=1 with gnt → pc=i_redirect_pc, drop=1, go to WAIT.
  - WAIT: o_mem_req=0.
    - i_mem_rvalid=1 and drop=0 and no redirect → inst_q=i_mem_rdata, go to HOLD.
    - i_mem_rvalid=1 and (drop=1 or i_redirect=1) → discard data, drop=0, go to REQ. If redirecting, pc=i_redirect_pc.
    - i_redirect=1 without rvalid → pc=i_redirect_pc, drop=1, stay in WAIT.
  - HOLD: o_inst_valid=1, o_inst=inst_q, o_pc=pc.
    - Transfer without redirect → pc=pc+4 (64-bit wrap, no overflow flag), go to REQ.
    - i_redirect=1, with or without transfer → pc=i_redirect_pc, go to REQ. Redirect wins the PC.
    - Otherwise hold; o_inst and o_pc remain stable while i_id_ready=0.
- o_inst=NOP_INST whenever o_inst_valid=0.
- i_mem_rvalid outside WAIT is ignored.
- Best-case latency: REQ+gnt at cycle n, rvalid at n+1, o_inst_valid at n+2. Sustained throughput is one instruction per 3 cycles.
- Only pc+4 is generated internally; pc[1:0] is otherwise unchecked.

Optional Feature:
YSYX_22050710_IFU_ALIGN_CHECK_EN
- Defined:
  - Adds output o_misalign (1 bit, reset 0).
  - A redirect with i_redirect_pc[1:0]!=0 still loads pc, sets o_misalign=1, and moves the FSM to IDLE_ERR.
  - IDLE_ERR issues no requests and holds o_inst_valid=0 until reset.
  - Any in-flight response arriving in IDLE_ERR is ignored.
- Undefined: no o_misalign port; redirect targets are loaded unchecked.

Test Plan:
1. Reset, mem grants immediately and returns 32'h00100093 one cycle after grant, i_id_ready=1 → o_mem_addr=0x80000000; o_inst_valid at cycle 3 after reset release with o_pc=0x80000000; next request to 0x80000004.
2. i_id_ready=0 for 5 cycles in HOLD → o_inst and o_pc stable and o_mem_req=0 throughout; ready=1 → one transfer, pc advances by exactly 4.
3. Redirect to 0x80000100 in WAIT, rvalid 2 cycles later with 32'hdeadbeef → data never appears on o_inst; next o_mem_addr=0x80000100.
4. Redirect to 0x80000200 in the same cycle as gnt → next response discarded, then a request to 0x80000200 follows.
5. Redirect in HOLD with i_id_ready=1 → pc=redirect target (not +4); i_rst asserted in WAIT → next cycle all outputs at reset values, o_pc=0x80000000.
6. (ALIGN_CHECK_EN) Redirect to 0x80000102 → o_misalign=1, o_mem_req stays 0 until reset.
